mc_ctrl_hs: RTL



---
 rtl/mc_ctrl_hs.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl_hs.sv
// Multi-cycle MIPS control FSM with instruction/data memory handshakes, wait-state timeout,
// sticky illegal/bus-error flags and HALT. Optional performance counters under MC_PERF_CNT_EN.
module mc_ctrl_hs #(
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned WAIT_W  = 5
`ifdef MC_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W   = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               sign,
  input  logic               imem_ack,
  input  logic               dmem_ack,
  output logic               imem_req,
  output logic               ir_wre,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               pc_wre,
  output logic [1:0]         pc_src,
  output logic               reg_wre,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               alu_src_b,
  output logic [1:0]         ext_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state_out,
  output logic               illegal,
  output logic               bus_err
`ifdef MC_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [CNT_W-1:0]   ret_cnt
`endif
);

  typedef enum logic [2:0] {
    StIf   = 3'b000,
    StId   = 3'b001,
    StExe  = 3'b010,
    StMem  = 3'b011,
    StWb   = 3'b100,
    StHalt = 3'b111
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBgtz  = 6'b000111;
  localparam logic [5:0] OpBgez  = 6'b000001;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnXor = 6'b100110;
  localparam logic [5:0] FnSlt = 6'b101010;
  localparam logic [5:0] FnJr  = 6'b001000;

  localparam logic [ALUOP_W-1:0] AluAdd = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluSub = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluAnd = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluOr  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluXor = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluSlt = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluLui = ALUOP_W'(6);

  localparam int unsigned       TimeoutLast = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [WAIT_W-1:0] WaitLast    = WAIT_W'(TimeoutLast);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;

  logic is_rtype, is_ralu, is_jr, is_j, is_jal, is_lw, is_sw;
  logic is_beq, is_bgtz, is_bgez, is_branch, is_imm, legal, taken, wait_hit;

  always_comb begin
    is_rtype  = (opcode == OpRtype);
    is_ralu   = is_rtype && (funct == FnAdd || funct == FnSub || funct == FnAnd ||
                             funct == FnOr  || funct == FnXor || funct == FnSlt);
    is_jr     = is_rtype && (funct == FnJr);
    is_j      = (opcode == OpJ);
    is_jal    = (opcode == OpJal);
    is_lw     = (opcode == OpLw);
    is_sw     = (opcode == OpSw);
    is_beq    = (opcode == OpBeq);
    is_bgtz   = (opcode == OpBgtz);
    is_bgez   = (opcode == OpBgez);
    is_branch = is_beq || is_bgtz || is_bgez;
    is_imm    = (opcode == OpAddi) || (opcode == OpAddiu) || (opcode == OpOri) ||
                (opcode == OpLui);
    legal     = is_ralu || is_jr || is_j || is_jal || is_lw || is_sw || is_branch || is_imm;
    taken     = is_beq ? zero : (is_bgtz ? (!sign && !zero) : !sign);
    wait_hit  = (TIMEOUT != 0) && (wait_q == WaitLast);
  end

  // ALU/extender controls decoded from the held IR; applied only in EXE/MEM/WB.
  logic [ALUOP_W-1:0] alu_op_dec;
  logic               alu_src_b_dec;
  logic [1:0]         ext_sel_dec;

  always_comb begin
    alu_op_dec    = AluAdd;
    alu_src_b_dec = 1'b1;
    ext_sel_dec   = 2'd1;
    if (is_rtype) begin
      alu_src_b_dec = 1'b0;
      ext_sel_dec   = 2'd0;
      case (funct)
        FnSub:   alu_op_dec = AluSub;
        FnAnd:   alu_op_dec = AluAnd;
        FnOr:    alu_op_dec = AluOr;
        FnXor:   alu_op_dec = AluXor;
        FnSlt:   alu_op_dec = AluSlt;
        default: alu_op_dec = AluAdd;
      endcase
    end else if (opcode == OpAddiu) begin
      ext_sel_dec = 2'd0;
    end else if (opcode == OpOri) begin
      alu_op_dec  = AluOr;
      ext_sel_dec = 2'd0;
    end else if (opcode == OpLui) begin
      alu_op_dec  = AluLui;
      ext_sel_dec = 2'd2;
    end else if (is_beq) begin
      // B comes from rt; the sign-extended immediate serves the branch target.
      alu_op_dec    = AluSub;
      alu_src_b_dec = 1'b0;
    end else if (is_bgtz || is_bgez) begin
      alu_op_dec  = AluSub;
      ext_sel_dec = 2'd3;
    end
  end

  logic imem_req_c, ir_wre_c, dmem_req_c, dmem_we_c, pc_wre_c, reg_wre_c;

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    imem_req_c = 1'b0;
    ir_wre_c   = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    pc_wre_c   = 1'b0;
    reg_wre_c  = 1'b0;
    pc_src     = 2'd0;
    reg_dst    = 2'd0;
    wb_sel     = 2'd0;
    alu_op     = AluAdd;
    alu_src_b  = 1'b0;
    ext_sel    = 2'd0;
    if (state_q == StExe || state_q == StMem || state_q == StWb) begin
      alu_op    = alu_op_dec;
      alu_src_b = alu_src_b_dec;
      ext_sel   = ext_sel_dec;
    end
    case (state_q)
      StIf: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_wre_c = 1'b1;
          state_d  = StId;
        end else if (wait_hit) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StId: begin
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = StHalt;
        end else if (is_j || is_jal) begin
          pc_wre_c = 1'b1;
          pc_src   = 2'd3;
          state_d  = StIf;
          if (is_jal) begin
            reg_wre_c = 1'b1;
            reg_dst   = 2'd2;
            wb_sel    = 2'd2;
          end
        end else if (is_jr) begin
          pc_wre_c = 1'b1;
          pc_src   = 2'd2;
          state_d  = StIf;
        end else begin
          state_d = StExe;
        end
      end
      StExe: begin
        if (is_branch) begin
          pc_wre_c = 1'b1;
          pc_src   = taken ? 2'd1 : 2'd0;
          state_d  = StIf;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sw;
        if (dmem_ack) begin
          if (is_sw) begin
            pc_wre_c = 1'b1;
            state_d  = StIf;
          end else begin
            state_d = StWb;
          end
        end else if (wait_hit) begin
          bus_err_d = 1'b1;
          state_d   = StHalt;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      StWb: begin
        reg_wre_c = 1'b1;
        pc_wre_c  = 1'b1;
        reg_dst   = is_rtype ? 2'd1 : 2'd0;
        wb_sel    = is_lw ? 2'd1 : 2'd0;
        state_d   = StIf;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIf;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobes are forced low for the whole reset cycle, whatever state is held.
  assign imem_req  = imem_req_c & ~reset;
  assign ir_wre    = ir_wre_c & ~reset;
  assign dmem_req  = dmem_req_c & ~reset;
  assign dmem_we   = dmem_we_c & ~reset;
  assign pc_wre    = pc_wre_c & ~reset;
  assign reg_wre   = reg_wre_c & ~reset;
  assign state_out = state_q;
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;

`ifdef MC_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;

  always_comb begin
    cyc_cnt_d = (state_q != StHalt) ? cyc_cnt_q + CNT_W'(1) : cyc_cnt_q;
    ret_cnt_d = pc_wre_c ? ret_cnt_q + CNT_W'(1) : ret_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule
